maxpool2: RTL and testbench

MAXPOOL2 -- requirements
Module: maxpool2

---
 rtl/maxpool2.sv | 143 ++++++++++++++
 tb/tb_maxpool2.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/maxpool2.sv
// 2x2 / stride-2 signed max-pooling over CH feature maps, one output pixel every
// five cycles (LOAD, three CMP, WRITE), handshaked by a level start / sticky done.
module maxpool2 #(
  parameter int CH      = 32,
  parameter int IN_DIM  = 14,
  localparam int OUT_DIM = IN_DIM / 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] in_maps  [CH][IN_DIM][IN_DIM],
  output logic               busy,
  output logic               done,
  output logic signed [31:0] out_maps [CH][OUT_DIM][OUT_DIM]
);

  localparam int FW = (CH > 1) ? $clog2(CH) : 1;
  localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IW = $clog2(IN_DIM);

  typedef enum logic [2:0] {IDLE, LOAD, CMP, WRITE, DONE, WAIT_START_LOW} state_t;

  state_t state_q, state_d;
  logic [FW-1:0] f_q, f_d;
  logic [OW-1:0] i_q, i_d, j_q, j_d;
  logic [1:0] k_q, k_d;
  logic signed [31:0] max_q, max_d;
  logic done_q, done_d;
  logic signed [31:0] out_maps_q [CH][OUT_DIM][OUT_DIM];

  logic dy, dx, wr_en, last_pix;
  logic [IW-1:0] row, col;
  logic signed [31:0] pix;

  assign last_pix = (f_q == FW'(CH - 1)) && (i_q == OW'(OUT_DIM - 1)) &&
                    (j_q == OW'(OUT_DIM - 1));

  // k selects the window offset in CMP: 1 -> (0,1), 2 -> (1,0), 3 -> (1,1)
  always_comb begin
    dy  = (state_q == CMP) && k_q[1];
    dx  = (state_q == CMP) && k_q[0];
    row = IW'({i_q, 1'b0}) + IW'(dy);
    col = IW'({j_q, 1'b0}) + IW'(dx);
    pix = in_maps[f_q][row][col];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      max_q   <= max_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (start) state_d = LOAD;
      LOAD:           state_d = CMP;
      CMP:            if (k_q == 2'd3) state_d = WRITE;
      WRITE:          state_d = last_pix ? DONE : LOAD;
      DONE:           state_d = WAIT_START_LOW;
      WAIT_START_LOW: if (!start) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    f_d    = f_q;
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    max_d  = max_q;
    done_d = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          f_d    = '0;
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
          done_d = 1'b0;
        end
      end
      LOAD: begin
        max_d = pix;
        k_d   = 2'd1;
      end
      CMP: begin
        // strict compare so ties keep the value already held
        if (pix > max_q) max_d = pix;
        k_d = k_q + 2'd1;
      end
      WRITE: begin
        if (j_q == OW'(OUT_DIM - 1)) begin
          j_d = '0;
          if (i_q == OW'(OUT_DIM - 1)) begin
            i_d = '0;
            f_d = f_q + FW'(1);
          end else begin
            i_d = i_q + OW'(1);
          end
        end else begin
          j_d = j_q + OW'(1);
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE) && (state_q != WAIT_START_LOW);
    wr_en = (state_q == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++)
        for (int y = 0; y < OUT_DIM; y++)
          for (int x = 0; x < OUT_DIM; x++)
            out_maps_q[c][y][x] <= '0;
    end else if (wr_en) begin
      out_maps_q[f_q][i_q][j_q] <= max_q;
    end
  end

  assign done     = done_q;
  assign out_maps = out_maps_q;

endmodule

// File: tb/tb_maxpool2.sv
// Directed self-checking bench for maxpool2 at default size: ramp data, signed
// corner windows, start handshake, mid-run reset and start glitches.
module tb_maxpool2;
  localparam int CH      = 32;
  localparam int IN_DIM  = 14;
  localparam int OUT_DIM = 7;
  localparam int LAT     = 5 * CH * OUT_DIM * OUT_DIM + 1;

  logic clk, reset, start, busy, done;
  logic signed [31:0] in_maps  [CH][IN_DIM][IN_DIM];
  logic signed [31:0] out_maps [CH][OUT_DIM][OUT_DIM];

  int n_compared = 0;
  int n_failed   = 0;
  int done_edge;

  maxpool2 #(.CH(CH), .IN_DIM(IN_DIM)) dut (
    .clk(clk), .reset(reset), .start(start), .in_maps(in_maps),
    .busy(busy), .done(done), .out_maps(out_maps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pattern 0: ramp; pattern 1: zeros plus corner values and signed windows
  task automatic applyStimulus(input int pattern);
    for (int c = 0; c < CH; c++)
      for (int y = 0; y < IN_DIM; y++)
        for (int x = 0; x < IN_DIM; x++)
          in_maps[c][y][x] = (pattern == 0) ? 32'(c * 1000 + y * 14 + x) : 32'sd0;
    if (pattern == 1) begin
      in_maps[0][0][0]    = 32'sh1234;
      in_maps[31][13][13] = 32'sh5678;
      in_maps[7][2][4] = -32'sd5;  in_maps[7][2][5] = -32'sd3;
      in_maps[7][3][4] = -32'sd7;  in_maps[7][3][5] = -32'sd9;
      in_maps[7][6][6] = -32'sd1;  in_maps[7][6][7] = 32'sh7FFFFFFF;
      in_maps[7][7][6] = 32'sh80000000; in_maps[7][7][7] = 32'sd0;
      in_maps[7][8][10] = 32'sd42; in_maps[7][8][11] = 32'sd42;
      in_maps[7][9][10] = 32'sd42; in_maps[7][9][11] = 32'sd42;
      in_maps[8][0][0] = -32'sd10; in_maps[8][0][1] = -32'sd20;
      in_maps[8][1][0] = -32'sd30; in_maps[8][1][1] = -32'sd4;
      in_maps[9][0][0] = -32'sd10; in_maps[9][0][1] = -32'sd20;
      in_maps[9][1][0] = -32'sd2;  in_maps[9][1][1] = -32'sd30;
    end
  endtask

  function automatic int count_nonzero();
    int n = 0;
    for (int c = 0; c < CH; c++)
      for (int y = 0; y < OUT_DIM; y++)
        for (int x = 0; x < OUT_DIM; x++)
          if (out_maps[c][y][x] != 0) n++;
    return n;
  endfunction

  task automatic check_ramp(input string tag);
    for (int c = 0; c < CH; c++)
      for (int y = 0; y < OUT_DIM; y++)
        for (int x = 0; x < OUT_DIM; x++)
          checkOutput(tag, out_maps[c][y][x], 32'(c * 1000 + (2 * y + 1) * 14 + 2 * x + 1));
  endtask

  // Edge 0 is the edge that samples start in IDLE; returns the first edge with done=1
  task automatic run_pool(input bit hold_start, input bit glitch, input bit order_chk,
                          output int first_done);
    first_done = -1;
    start = 1'b1;
    for (int e = 0; e < 8000 && first_done < 0; e++) begin
      @(posedge clk);
      #1;
      if (done) first_done = e;
      if (e == 0) begin
        checkOutput("accept_done_low", done, 0);
        checkOutput("accept_busy_high", busy, 1);
        if (!hold_start) start = 1'b0;
      end
      if (glitch && e == 99)  start = 1'b1;
      if (glitch && e == 100) start = 1'b0;
      if (order_chk) begin
        if (e == 4)   checkOutput("order_e4_px0_unwritten", out_maps[0][0][0], 0);
        if (e == 5)   checkOutput("order_e5_px0", out_maps[0][0][0], 15);
        if (e == 5)   checkOutput("order_e5_px1_unwritten", out_maps[0][0][1], 0);
        if (e == 10)  checkOutput("order_e10_px1", out_maps[0][0][1], 17);
        if (e == 40)  checkOutput("order_e40_row0_end", out_maps[0][0][6], 27);
        if (e == 40)  checkOutput("order_e40_row1_start", out_maps[0][1][0], 43);
        if (e == 245) checkOutput("order_e245_map0_end", out_maps[0][6][6], 195);
        if (e == 245) checkOutput("order_e245_map1_unwritten", out_maps[1][0][0], 0);
        if (e == 250) checkOutput("order_e250_map1_start", out_maps[1][0][0], 1015);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(0);
    #1;
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_zero", count_nonzero(), 0);
    step(2);
    reset = 1'b0;
    step(2);
    checkOutput("idle_busy", busy, 0);

    // Ramp run with start held high throughout
    run_pool(1'b1, 1'b0, 1'b1, done_edge);
    checkOutput("ramp_latency", done_edge, LAT);
    check_ramp("ramp_result");
    step(30);
    checkOutput("hold_no_retrigger_busy", busy, 0);
    checkOutput("hold_done_kept", done, 1);
    start = 1'b0;
    step(3);
    checkOutput("start_low_done_kept", done, 1);
    checkOutput("start_low_busy", busy, 0);

    // Second run on the same data after start goes low then high
    run_pool(1'b0, 1'b0, 1'b0, done_edge);
    checkOutput("rerun_latency", done_edge, LAT);
    check_ramp("rerun_result");

    // Abort a run at cycle 3000 with reset
    step(2);
    run_pool(1'b0, 1'b0, 1'b0, done_edge);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2999);
    checkOutput("midrun_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_done", done, 0);
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_out_zero", count_nonzero(), 0);
    step(2);
    reset = 1'b0;
    step(1);

    // Restart with corner / signed-window data
    applyStimulus(1);
    run_pool(1'b0, 1'b0, 1'b0, done_edge);
    checkOutput("corner_latency", done_edge, LAT);
    checkOutput("corner_first", out_maps[0][0][0], 32'sh1234);
    checkOutput("corner_last", out_maps[31][6][6], 32'sh5678);
    checkOutput("signed_all_neg", out_maps[7][1][2], -32'sd3);
    checkOutput("signed_extremes", out_maps[7][3][3], 32'sh7FFFFFFF);
    checkOutput("signed_all_equal", out_maps[7][4][5], 32'sd42);
    checkOutput("signed_max_at_11", out_maps[8][0][0], -32'sd4);
    checkOutput("signed_max_at_10", out_maps[9][0][0], -32'sd2);
    checkOutput("corner_nonzero_count", count_nonzero(), 7);

    // Ramp again with start glitching while busy
    start = 1'b0;
    step(2);
    applyStimulus(0);
    run_pool(1'b0, 1'b1, 1'b0, done_edge);
    checkOutput("glitch_latency", done_edge, LAT);
    check_ramp("glitch_result");
    step(5);
    checkOutput("glitch_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
